// File: rtl/db_ram_pp_dp_pkg.sv
// Shared definitions for the ping-pong dual-port buffer:
// bank index width, active-low enable encodings and bank control state.
package db_ram_pp_dp_pkg;

    localparam int BANK_W    = 1;
    localparam int NUM_BANKS = 2;

    localparam logic EN_ACT  = 1'b0;
    localparam logic EN_IDLE = 1'b1;

    typedef logic [BANK_W-1:0] bank_t;

    typedef struct packed {
        logic [NUM_BANKS-1:0] full;
        bank_t                wr_ptr;
        bank_t                rd_ptr;
    } bank_ctrl_t;

    localparam bank_ctrl_t CTRL_RST = '{full: '0, wr_ptr: '0, rd_ptr: '0};

    function automatic logic [1:0] full_count(input logic [NUM_BANKS-1:0] f);
        return {1'b0, f[0]} + {1'b0, f[1]};
    endfunction

endpackage

// File: rtl/ram_dp.sv
// Simple dual-port RAM: port A writes, port B reads, active-low enables.
// Registered read, read-first on same-address collision; contents never reset.
module ram_dp #(
    parameter int WORD_WIDTH = 20,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clka,
    input  logic                  cena_i,
    input  logic                  wena_i,
    input  logic [ADDR_WIDTH-1:0] addra_i,
    input  logic [WORD_WIDTH-1:0] dataa_i,
    input  logic                  clkb,
    input  logic                  cenb_i,
    input  logic [ADDR_WIDTH-1:0] addrb_i,
    output logic [WORD_WIDTH-1:0] datab_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [WORD_WIDTH-1:0] mem [DEPTH];
    logic [WORD_WIDTH-1:0] datab_q;

    always_ff @(posedge clka) begin
        if (!cena_i && !wena_i) begin
            mem[addra_i] <= dataa_i;
        end
    end

    always_ff @(posedge clkb) begin
        if (!cenb_i) begin
            datab_q <= mem[addrb_i];
        end
    end

    assign datab_o = datab_q;

endmodule

// File: rtl/db_ram_pp_dp.sv
// Ping-pong dual-port buffer: producer fills one bank while the consumer
// drains the other; ownership moves on done handshakes.
module db_ram_pp_dp
    import db_ram_pp_dp_pkg::*;
#(
    parameter int WORD_WIDTH = 20,
    parameter int ADDR_WIDTH = 7,
    parameter int OUT_REG    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_cen_i,
    input  logic                  wr_wen_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [WORD_WIDTH-1:0] wr_data_i,
    input  logic                  wr_done_i,
    output logic                  wr_rdy_o,
    output logic                  wr_bank_o,
    input  logic                  rd_cen_i,
    input  logic                  rd_oen_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [WORD_WIDTH-1:0] rd_data_o,
    output logic                  rd_vld_o,
    input  logic                  rd_done_i,
    output logic                  rd_rdy_o,
    output logic                  rd_bank_o,
    output logic [1:0]            full_cnt_o
);

    bank_ctrl_t ctrl_q, ctrl_d;

    logic wr_rdy, rd_rdy;
    logic wr_acc, rd_acc;
    logic wr_swap, rd_swap;
    logic ram_cena, ram_cenb;

    logic [ADDR_WIDTH:0]   wr_paddr, rd_paddr;
    logic [WORD_WIDTH-1:0] ram_q, rd_word;

    always_comb begin
        wr_rdy  = ~ctrl_q.full[ctrl_q.wr_ptr];
        rd_rdy  = ctrl_q.full[ctrl_q.rd_ptr];
        wr_acc  = ~rst & (wr_cen_i == EN_ACT) & (wr_wen_i == EN_ACT) & wr_rdy;
        rd_acc  = ~rst & (rd_cen_i == EN_ACT);
        wr_swap = wr_done_i & wr_rdy;
        rd_swap = rd_done_i & rd_rdy;
    end

    // Both swaps valid implies the pointers differ, so the flag updates never overlap.
    always_comb begin
        ctrl_d = ctrl_q;
        if (wr_swap) begin
            ctrl_d.full[ctrl_q.wr_ptr] = 1'b1;
            ctrl_d.wr_ptr              = ~ctrl_q.wr_ptr;
        end
        if (rd_swap) begin
            ctrl_d.full[ctrl_q.rd_ptr] = 1'b0;
            ctrl_d.rd_ptr              = ~ctrl_q.rd_ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q <= CTRL_RST;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    always_comb begin
        wr_paddr = {ctrl_q.wr_ptr, wr_addr_i};
        rd_paddr = {ctrl_q.rd_ptr, rd_addr_i};
        ram_cena = wr_acc ? EN_ACT : EN_IDLE;
        ram_cenb = rd_acc ? EN_ACT : EN_IDLE;
    end

    ram_dp #(
        .WORD_WIDTH(WORD_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH + 1)
    ) u_ram (
        .clka    (clk),
        .cena_i  (ram_cena),
        .wena_i  (EN_ACT),
        .addra_i (wr_paddr),
        .dataa_i (wr_data_i),
        .clkb    (clk),
        .cenb_i  (ram_cenb),
        .addrb_i (rd_paddr),
        .datab_o (ram_q)
    );

    generate
        if (OUT_REG == 0) begin : g_direct
            // RAM output is not reset, so mask it until the first read after reset.
            logic have_q, have_d;
            logic vld_q, vld_d;

            always_comb begin
                have_d = have_q | rd_acc;
                vld_d  = rd_acc;
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    have_q <= 1'b0;
                    vld_q  <= 1'b0;
                end else begin
                    have_q <= have_d;
                    vld_q  <= vld_d;
                end
            end

            assign rd_word  = have_q ? ram_q : '0;
            assign rd_vld_o = vld_q;
        end else begin : g_oreg
            logic                  vld1_q, vld1_d;
            logic                  vld2_q, vld2_d;
            logic [WORD_WIDTH-1:0] data_q, data_d;

            always_comb begin
                vld1_d = rd_acc;
                vld2_d = vld1_q;
                data_d = vld1_q ? ram_q : data_q;
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    vld1_q <= 1'b0;
                    vld2_q <= 1'b0;
                    data_q <= '0;
                end else begin
                    vld1_q <= vld1_d;
                    vld2_q <= vld2_d;
                    data_q <= data_d;
                end
            end

            assign rd_word  = data_q;
            assign rd_vld_o = vld2_q;
        end
    endgenerate

    assign rd_data_o  = (rd_oen_i == EN_IDLE) ? '0 : rd_word;
    assign wr_rdy_o   = wr_rdy;
    assign rd_rdy_o   = rd_rdy;
    assign wr_bank_o  = ctrl_q.wr_ptr;
    assign rd_bank_o  = ctrl_q.rd_ptr;
    assign full_cnt_o = full_count(ctrl_q.full);

endmodule

// File: tb/tb_db_ram_pp_dp.sv
// Bench for db_ram_pp_dp: both OUT_REG variants driven in lockstep and
// checked against a bank/array model plus handshake tables.
module tb_db_ram_pp_dp;

    localparam int WW = 20;
    localparam int AW = 7;
    localparam int D  = 2 ** AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_cen_i, wr_wen_i, wr_done_i;
    logic [AW-1:0] wr_addr_i;
    logic [WW-1:0] wr_data_i;
    logic          rd_cen_i, rd_oen_i, rd_done_i;
    logic [AW-1:0] rd_addr_i;

    logic          u0_wr_rdy, u0_wr_bank, u0_rd_vld, u0_rd_rdy, u0_rd_bank;
    logic [WW-1:0] u0_rd_data;
    logic [1:0]    u0_full_cnt;
    logic          u1_wr_rdy, u1_wr_bank, u1_rd_vld, u1_rd_rdy, u1_rd_bank;
    logic [WW-1:0] u1_rd_data;
    logic [1:0]    u1_full_cnt;

    always #5 clk = ~clk;

    db_ram_pp_dp #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW), .OUT_REG(0)) u0 (
        .clk(clk), .rst(rst),
        .wr_cen_i(wr_cen_i), .wr_wen_i(wr_wen_i), .wr_addr_i(wr_addr_i),
        .wr_data_i(wr_data_i), .wr_done_i(wr_done_i),
        .wr_rdy_o(u0_wr_rdy), .wr_bank_o(u0_wr_bank),
        .rd_cen_i(rd_cen_i), .rd_oen_i(rd_oen_i), .rd_addr_i(rd_addr_i),
        .rd_data_o(u0_rd_data), .rd_vld_o(u0_rd_vld), .rd_done_i(rd_done_i),
        .rd_rdy_o(u0_rd_rdy), .rd_bank_o(u0_rd_bank), .full_cnt_o(u0_full_cnt)
    );

    db_ram_pp_dp #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW), .OUT_REG(1)) u1 (
        .clk(clk), .rst(rst),
        .wr_cen_i(wr_cen_i), .wr_wen_i(wr_wen_i), .wr_addr_i(wr_addr_i),
        .wr_data_i(wr_data_i), .wr_done_i(wr_done_i),
        .wr_rdy_o(u1_wr_rdy), .wr_bank_o(u1_wr_bank),
        .rd_cen_i(rd_cen_i), .rd_oen_i(rd_oen_i), .rd_addr_i(rd_addr_i),
        .rd_data_o(u1_rd_data), .rd_vld_o(u1_rd_vld), .rd_done_i(rd_done_i),
        .rd_rdy_o(u1_rd_rdy), .rd_bank_o(u1_rd_bank), .full_cnt_o(u1_full_cnt)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: bank flags, pointers, memory image, per-variant output.
    bit            full [2];
    int            wp, rp;
    logic [WW-1:0] mem   [2][D];
    bit            known [2][D];
    bit            e_vld   [2];
    logic [WW-1:0] e_data  [2];
    bit            e_known [2];
    bit            s1_acc, s1_known;
    logic [WW-1:0] s1_data;

    typedef struct {
        bit wd;
        bit rdn;
        int cnt;
        int wb;
        int rb;
        bit wrdy;
        bit rrdy;
    } hs_vec_t;

    hs_vec_t tbl [8];

    task automatic chk(input string nm, input int k,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s u%0d got=%0h exp=%0h t=%0t", nm, k, act, exp, $time);
        end
    endtask

    task automatic chk_both(input string nm, input logic [31:0] a0,
                            input logic [31:0] a1, input logic [31:0] exp);
        chk(nm, 0, a0, exp);
        chk(nm, 1, a1, exp);
    endtask

    task automatic compare();
        logic          vld, wrdy, rrdy, wb, rb;
        logic [WW-1:0] data;
        logic [1:0]    cnt;
        for (int k = 0; k < 2; k++) begin
            vld  = (k == 0) ? u0_rd_vld   : u1_rd_vld;
            data = (k == 0) ? u0_rd_data  : u1_rd_data;
            wrdy = (k == 0) ? u0_wr_rdy   : u1_wr_rdy;
            rrdy = (k == 0) ? u0_rd_rdy   : u1_rd_rdy;
            wb   = (k == 0) ? u0_wr_bank  : u1_wr_bank;
            rb   = (k == 0) ? u0_rd_bank  : u1_rd_bank;
            cnt  = (k == 0) ? u0_full_cnt : u1_full_cnt;
            chk("rd_vld", k, vld, e_vld[k]);
            if (rd_oen_i) chk("rd_data_gated", k, data, 0);
            else if (e_known[k]) chk("rd_data", k, data, e_data[k]);
            chk("wr_rdy", k, wrdy, !full[wp]);
            chk("rd_rdy", k, rrdy, full[rp]);
            chk("full_cnt", k, cnt, int'(full[0]) + int'(full[1]));
            chk("wr_bank", k, wb, wp);
            chk("rd_bank", k, rb, rp);
        end
    endtask

    task automatic tick();
        bit            racc, wacc, wv, rv, rk;
        logic [WW-1:0] rdat;
        racc = !rst && !rd_cen_i;
        rdat = mem[rp][rd_addr_i];
        rk   = known[rp][rd_addr_i];
        wacc = !rst && !wr_cen_i && !wr_wen_i && !full[wp];
        wv   = wr_done_i && !full[wp];
        rv   = rd_done_i && full[rp];
        if (rst) begin
            full[0] = 0; full[1] = 0; wp = 0; rp = 0;
            for (int k = 0; k < 2; k++) begin
                e_vld[k] = 0; e_data[k] = '0; e_known[k] = 1;
            end
            s1_acc = 0; s1_data = '0; s1_known = 1;
        end else begin
            e_vld[1] = s1_acc;
            if (s1_acc) begin e_data[1] = s1_data; e_known[1] = s1_known; end
            s1_acc = racc; s1_data = rdat; s1_known = rk;
            e_vld[0] = racc;
            if (racc) begin e_data[0] = rdat; e_known[0] = rk; end
            if (wacc) begin
                mem[wp][wr_addr_i]   = wr_data_i;
                known[wp][wr_addr_i] = 1;
            end
            if (wv) begin full[wp] = 1; wp ^= 1; end
            if (rv) begin full[rp] = 0; rp ^= 1; end
        end
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic idle();
        rst = 0; wr_cen_i = 1; wr_wen_i = 1; wr_done_i = 0;
        wr_addr_i = '0; wr_data_i = '0;
        rd_cen_i = 1; rd_oen_i = 0; rd_done_i = 0; rd_addr_i = '0;
    endtask

    task automatic do_reset();
        idle(); rst = 1; tick(); rst = 0;
    endtask

    task automatic fill(input int base);
        for (int i = 0; i < D; i++) begin
            wr_cen_i = 0; wr_wen_i = 0; wr_addr_i = AW'(i);
            wr_data_i = WW'(base + i); tick();
        end
        idle(); wr_done_i = 1; tick(); idle();
    endtask

    initial begin
        tbl[0] = '{1, 0, 1, 1, 0, 1, 1};
        tbl[1] = '{1, 1, 1, 0, 1, 1, 1};
        tbl[2] = '{1, 1, 1, 1, 0, 1, 1};
        tbl[3] = '{1, 0, 2, 0, 0, 0, 1};
        tbl[4] = '{1, 0, 2, 0, 0, 0, 1};
        tbl[5] = '{0, 1, 1, 0, 1, 1, 1};
        tbl[6] = '{0, 1, 0, 0, 0, 1, 0};
        tbl[7] = '{0, 1, 0, 0, 0, 1, 0};

        // Reset values
        do_reset();
        chk_both("rst_wr_rdy", u0_wr_rdy, u1_wr_rdy, 1);
        chk_both("rst_rd_rdy", u0_rd_rdy, u1_rd_rdy, 0);
        chk_both("rst_full_cnt", u0_full_cnt, u1_full_cnt, 0);
        chk_both("rst_rd_data", u0_rd_data, u1_rd_data, 0);

        // Handshake table
        for (int i = 0; i < 8; i++) begin
            idle(); wr_done_i = tbl[i].wd; rd_done_i = tbl[i].rdn; tick();
            chk_both($sformatf("tbl%0d_cnt", i), u0_full_cnt, u1_full_cnt, tbl[i].cnt);
            chk_both($sformatf("tbl%0d_wb", i), u0_wr_bank, u1_wr_bank, tbl[i].wb);
            chk_both($sformatf("tbl%0d_rb", i), u0_rd_bank, u1_rd_bank, tbl[i].rb);
            chk_both($sformatf("tbl%0d_wrdy", i), u0_wr_rdy, u1_wr_rdy, tbl[i].wrdy);
            chk_both($sformatf("tbl%0d_rrdy", i), u0_rd_rdy, u1_rd_rdy, tbl[i].rrdy);
        end
        idle(); tick();

        // Fill bank 0 with data=addr, then drain with latency checks
        do_reset();
        fill(0);
        chk_both("fill_rd_rdy", u0_rd_rdy, u1_rd_rdy, 1);
        chk_both("fill_full_cnt", u0_full_cnt, u1_full_cnt, 1);
        for (int i = 0; i < D; i++) begin
            rd_cen_i = 0; rd_addr_i = AW'(i); tick();
            if (i == 0) begin
                chk("lat_vld_n1", 0, u0_rd_vld, 1);
                chk("lat_vld_n1", 1, u1_rd_vld, 0);
                chk("lat_data_n1", 0, u0_rd_data, 0);
            end
            if (i == 1) begin
                chk("lat_data_n2", 1, u1_rd_data, 0);
                chk("lat_vld_n2", 1, u1_rd_vld, 1);
            end
        end
        idle(); tick(); tick();

        // Both banks full: dropped write
        fill(200);
        chk_both("full2_cnt", u0_full_cnt, u1_full_cnt, 2);
        chk_both("full2_wr_rdy", u0_wr_rdy, u1_wr_rdy, 0);
        wr_cen_i = 0; wr_wen_i = 0; wr_addr_i = 5; wr_data_i = 20'hABCDE; tick();
        idle(); rd_cen_i = 0; rd_addr_i = 5; tick();
        chk("drop_data", 0, u0_rd_data, 5);
        idle(); tick();
        chk("drop_data", 1, u1_rd_data, 5);

        // Read-first collision with equal pointers
        do_reset();
        wr_cen_i = 0; wr_wen_i = 0; wr_addr_i = 9; wr_data_i = 20'h00111; tick();
        rd_cen_i = 0; rd_addr_i = 9; wr_data_i = 20'h00222; tick();
        chk("coll_old", 0, u0_rd_data, 20'h00111);
        idle(); rd_cen_i = 0; rd_addr_i = 9; tick();
        chk("coll_new", 0, u0_rd_data, 20'h00222);
        chk("coll_old", 1, u1_rd_data, 20'h00111);
        idle(); tick();
        chk("coll_new", 1, u1_rd_data, 20'h00222);

        // Output enable gating
        rd_cen_i = 0; rd_oen_i = 1; rd_addr_i = 9; tick();
        chk("oen_data", 0, u0_rd_data, 0);
        chk("oen_vld", 0, u0_rd_vld, 1);
        idle(); tick();
        chk("oen_held", 0, u0_rd_data, 20'h00222);
        chk("oen_vld", 1, u1_rd_vld, 1);

        // Reset mid-fill with a read in flight
        wr_cen_i = 0; wr_wen_i = 0; wr_addr_i = 3; wr_data_i = 20'h00333; tick();
        rd_cen_i = 0; rd_addr_i = 9; wr_addr_i = 4; tick();
        rst = 1; tick();
        chk_both("mrst_vld", u0_rd_vld, u1_rd_vld, 0);
        chk_both("mrst_data", u0_rd_data, u1_rd_data, 0);
        chk_both("mrst_wr_rdy", u0_wr_rdy, u1_wr_rdy, 1);
        idle(); tick();
        chk_both("mrst_vld_after", u0_rd_vld, u1_rd_vld, 0);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(0, 399) == 0);
            wr_cen_i  = ($urandom_range(0, 3) == 0);
            wr_wen_i  = ($urandom_range(0, 7) == 0);
            wr_addr_i = AW'($urandom);
            wr_data_i = WW'($urandom);
            wr_done_i = ($urandom_range(0, 29) == 0);
            rd_cen_i  = ($urandom_range(0, 2) == 0);
            rd_oen_i  = ($urandom_range(0, 7) == 0);
            rd_addr_i = AW'($urandom);
            rd_done_i = ($urandom_range(0, 29) == 0);
            tick();
        end
        idle(); tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
